// File: rtl/mem_access.sv
// Memory stage: accepts the EXE->MEM bus, runs one data-memory access and hands the result to WB.
// Optional bus watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for MEM_valid; latches the incoming bus on accept
// ACCESS | dm_req asserted, waiting for dm_ready (or watchdog expiry)
// DONE   | MEM_over pulse, MEM_WB_bus valid, local exception reported
module mem_access (
    input  logic         clk,
    input  logic         resetn,
    input  logic         MEM_valid,
    input  logic [108:0] EXE_MEM_bus_r,
    output logic         dm_req,
    output logic [31:0]  dm_addr,
    output logic [3:0]   dm_we,
    output logic [31:0]  dm_wdata,
    input  logic [31:0]  dm_rdata,
    input  logic         dm_ready,
    output logic         MEM_over,
    output logic [72:0]  MEM_WB_bus,
    output logic         mem_exception_flag,
    output logic [1:0]   mem_exception_type,
    output logic [31:0]  MEM_pc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;

    logic [1:0]  in_exc_type;
    logic        in_exc_flag;
    logic        in_load;
    logic        in_store;
    logic        in_byte;
    logic        in_sext;
    logic [31:0] in_alu;
    logic [31:0] in_sd;
    logic        in_wen;
    logic [4:0]  in_dest;
    logic [31:0] in_pc;

    assign {in_exc_type, in_exc_flag, in_load, in_store, in_byte, in_sext,
            in_alu, in_sd, in_wen, in_dest, in_pc} = EXE_MEM_bus_r;

    logic        in_local_exc;
    logic [1:0]  local_type;
    logic        in_mem;
    logic [3:0]  in_we;
    logic [31:0] in_wdata;
    logic [1:0]  done_type;
    logic        done_flag;

    // Byte accesses can never be misaligned; load takes precedence if both bits are set.
    assign in_local_exc = !in_exc_flag && !in_byte && (in_alu[1:0] != 2'b00)
                          && (in_load || in_store);
    assign local_type   = in_load ? 2'b01 : 2'b10;
    assign in_mem       = (in_load || in_store) && !in_exc_flag && !in_local_exc;
    assign in_we        = !in_store ? 4'b0000 :
                          (in_byte ? (4'b0001 << in_alu[1:0]) : 4'b1111);
    assign in_wdata     = in_byte ? {4{in_sd[7:0]}} : in_sd;
    assign done_flag    = in_exc_flag || in_local_exc;
    assign done_type    = in_exc_flag ? in_exc_type : (in_local_exc ? local_type : 2'b00);

    logic        lat_load;
    logic        lat_byte;
    logic        lat_sext;
    logic [31:0] lat_alu;
    logic        lat_wen;
    logic [4:0]  lat_dest;

    logic [7:0]  rd_byte;
    logic [31:0] load_result;

    always_comb begin
        rd_byte = dm_rdata[7:0];
        case (lat_alu[1:0])
            2'd1:    rd_byte = dm_rdata[15:8];
            2'd2:    rd_byte = dm_rdata[23:16];
            2'd3:    rd_byte = dm_rdata[31:24];
            default: rd_byte = dm_rdata[7:0];
        endcase
    end

    assign load_result = lat_byte ? {{24{lat_sext & rd_byte[7]}}, rd_byte} : dm_rdata;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [7:0] wd_cnt;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state              <= IDLE;
            dm_req             <= 1'b0;
            dm_addr            <= '0;
            dm_we              <= '0;
            dm_wdata           <= '0;
            MEM_over           <= 1'b0;
            MEM_WB_bus         <= '0;
            mem_exception_flag <= 1'b0;
            mem_exception_type <= 2'b00;
            MEM_pc             <= '0;
            lat_load           <= 1'b0;
            lat_byte           <= 1'b0;
            lat_sext           <= 1'b0;
            lat_alu            <= '0;
            lat_wen            <= 1'b0;
            lat_dest           <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wd_cnt             <= '0;
`endif
        end else begin
            MEM_over           <= 1'b0;
            mem_exception_flag <= 1'b0;
            mem_exception_type <= 2'b00;
            case (state)
                IDLE: begin
                    if (MEM_valid) begin
                        lat_load <= in_load;
                        lat_byte <= in_byte;
                        lat_sext <= in_sext;
                        lat_alu  <= in_alu;
                        lat_wen  <= in_wen;
                        lat_dest <= in_dest;
                        MEM_pc   <= in_pc;
                        if (in_mem) begin
                            state    <= ACCESS;
                            dm_req   <= 1'b1;
                            dm_addr  <= {in_alu[31:2], 2'b00};
                            dm_we    <= in_we;
                            dm_wdata <= in_wdata;
`ifdef MEM_ACCESS_TIMEOUT_EN
                            wd_cnt   <= '0;
`endif
                        end else begin
                            state              <= DONE;
                            MEM_over           <= 1'b1;
                            MEM_WB_bus         <= {done_type, done_flag, in_wen & ~done_flag,
                                                   in_dest, in_alu, in_pc};
                            mem_exception_flag <= in_local_exc;
                            mem_exception_type <= in_local_exc ? local_type : 2'b00;
                        end
                    end
                end
                ACCESS: begin
                    if (dm_ready) begin
                        state      <= DONE;
                        dm_req     <= 1'b0;
                        dm_we      <= 4'b0000;
                        MEM_over   <= 1'b1;
                        MEM_WB_bus <= {2'b00, 1'b0, lat_wen, lat_dest,
                                       lat_load ? load_result : lat_alu, MEM_pc};
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else begin
                        wd_cnt <= wd_cnt + 8'd1;
                        // The 255th unanswered cycle ends the access with an address-error style fault.
                        if (wd_cnt == 8'd254) begin
                            state              <= DONE;
                            dm_req             <= 1'b0;
                            dm_we              <= 4'b0000;
                            MEM_over           <= 1'b1;
                            MEM_WB_bus         <= {lat_load ? 2'b01 : 2'b10, 1'b1, 1'b0,
                                                   lat_dest, lat_alu, MEM_pc};
                            mem_exception_flag <= 1'b1;
                            mem_exception_type <= lat_load ? 2'b01 : 2'b10;
                        end
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
